scalar_writeback_stage: RTL

// - Final scalar pipeline stage; sole driver of the scalar register file write port.
// - Merges two result sources:
//   - execute-pipeline results, which have fixed timing;
//   - data-cache load results, which can arrive in any cycle.
// - Execute always wins a conflict. A losing load waits in a small in-order FIFO and drains on later idle slots.
// - Writeback outputs are registered. They also drive decode's bypass, which covers the register file's same-cycle read/write X.
//

---
 rtl/scalar_writeback_stage_pkg.sv | 13 +
 rtl/scalar_wb_fifo.sv | 61 ++++++
 rtl/scalar_writeback_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/scalar_writeback_stage_pkg.sv
// Shared types for the scalar writeback stage: register index width and the
// {register, value} pair carried by every writeback source.
package scalar_writeback_stage_pkg;

    // {strand, reg} destination index
    localparam int REG_IDX_WIDTH = 7;

    typedef struct packed {
        logic [REG_IDX_WIDTH-1:0] reg_idx;
        logic [31:0]              value;
    } scalar_wb_t;

endpackage

// File: rtl/scalar_wb_fifo.sv
// Small synchronous FIFO of load results that lost arbitration to execute.
// Head data is read combinationally; push and pop may happen in the same cycle.
module scalar_wb_fifo
    import scalar_writeback_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  scalar_wb_t               push_data,
    input  logic                     pop,
    output scalar_wb_t               head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    scalar_wb_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign head_data = mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scalar_writeback_stage.sv
// Final scalar pipeline stage: merges execute results and data-cache loads onto
// the single register file write port, buffering loads that lose to execute.
module scalar_writeback_stage
    import scalar_writeback_stage_pkg::*;
#(
    parameter int LOAD_FIFO_DEPTH = 4,
    parameter int LOAD_SKID       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_writeback_en,
    input  logic [REG_IDX_WIDTH-1:0] ex_writeback_reg,
    input  logic [31:0]              ex_writeback_value,
    input  logic                     dc_load_valid,
    input  logic [REG_IDX_WIDTH-1:0] dc_load_reg,
    input  logic [31:0]              dc_load_value,
    output logic                     wb_load_stall,
    output logic                     wb_enable_scalar_writeback,
    output logic [REG_IDX_WIDTH-1:0] wb_writeback_reg,
    output logic [31:0]              wb_writeback_value,
    output logic                     wb_load_overflow
);

    localparam int CNT_W = $clog2(LOAD_FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(LOAD_FIFO_DEPTH - LOAD_SKID);

    scalar_wb_t       load_entry;
    scalar_wb_t       fifo_head;
    scalar_wb_t       sel_data;
    logic             sel_valid;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             push_accept;
    logic             push_dropped;
    logic [CNT_W-1:0] next_count;

    assign load_entry = '{reg_idx: dc_load_reg, value: dc_load_value};

    scalar_wb_fifo #(
        .DEPTH(LOAD_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (load_entry),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Execute has fixed timing so it always wins; buffered loads go before a
    // new load so results retire in arrival order.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (ex_writeback_en) begin
            sel_valid = 1'b1;
            sel_data  = '{reg_idx: ex_writeback_reg, value: ex_writeback_value};
            fifo_push = dc_load_valid;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_data  = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = dc_load_valid;
        end else if (dc_load_valid) begin
            sel_valid = 1'b1;
            sel_data  = load_entry;
        end
    end

    always_comb begin
        push_accept  = fifo_push && (!fifo_full || fifo_pop);
        push_dropped = fifo_push && fifo_full && !fifo_pop;
        next_count   = fifo_count;
        case ({push_accept, fifo_pop})
            2'b10:   next_count = fifo_count + 1'b1;
            2'b01:   next_count = fifo_count - 1'b1;
            default: next_count = fifo_count;
        endcase
    end

    // Register index/value hold on idle cycles so decode's bypass stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_enable_scalar_writeback <= 1'b0;
            wb_writeback_reg           <= '0;
            wb_writeback_value         <= '0;
            wb_load_stall              <= 1'b0;
            wb_load_overflow           <= 1'b0;
        end else begin
            wb_enable_scalar_writeback <= sel_valid;
            if (sel_valid) begin
                wb_writeback_reg   <= sel_data.reg_idx;
                wb_writeback_value <= sel_data.value;
            end
            wb_load_stall <= (next_count >= STALL_LEVEL);
            if (push_dropped) begin
                wb_load_overflow <= 1'b1;
            end
        end
    end

endmodule
